sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_rr_pick.sv | 47 ++++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM arbiter.
package sram_pkg;

  localparam int AW_DEFAULT = 18;
  localparam int DW_DEFAULT = 16;

  // Transfer sequencer states: two-cycle read, three-cycle write.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5
  } state_e;

  // Identifies a requesting port.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-request round-robin picker. When both ports ask at once, the port
// that was not granted last wins. The memory of who went last lives here.
module sram_rr_pick
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic gnt_a,
  output logic gnt_b
);

  port_e last_grant;

  // Grant decision; only meaningful while the sequencer can accept work.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (a_req && b_req) begin
        gnt_a = (last_grant == PORT_B);
        gnt_b = (last_grant == PORT_A);
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

  // Remember the winner; reset favours B as "last" so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    if (!rst_n) begin
      last_grant <= PORT_B;
    end else if (gnt_a) begin
      last_grant <= PORT_A;
    end else if (gnt_b) begin
      last_grant <= PORT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous SRAM arbiter. Port A (CPU) reads and writes,
// port B (video) only reads. All SRAM pins are registered; the data bus is
// driven only while a write sequence is in progress.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic [AW-1:0] ADDR,
  inout  wire  [DW-1:0] DATA,
  output logic          CSX,
  output logic          OEX,
  output logic          WEX
);

  state_e        state;
  state_e        state_nxt;
  port_e         owner;
  logic          gnt_a;
  logic          gnt_b;
  logic          data_oe;
  logic [DW-1:0] wdata_q;

  sram_rr_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .a_req (a_req),
    .b_req (b_req),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Next-state sequencing; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (gnt_a)      state_nxt = a_we ? WR1 : RD1;
        else if (gnt_b) state_nxt = RD1;
      end
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = IDLE;
      WR1:     state_nxt = WR2;
      WR2:     state_nxt = WR3;
      WR3:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pin registers follow the state being entered, so strobes change on the
  // same edge as the state; address and write data are latched on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ADDR    <= '0;
      CSX     <= 1'b1;
      OEX     <= 1'b1;
      WEX     <= 1'b1;
      data_oe <= 1'b0;
      wdata_q <= '0;
      owner   <= PORT_A;
    end else begin
      CSX     <= (state_nxt == IDLE);
      OEX     <= !(state_nxt inside {RD1, RD2});
      WEX     <= (state_nxt != WR2);
      data_oe <= (state_nxt inside {WR1, WR2, WR3});
      if (gnt_a) begin
        ADDR    <= a_addr;
        wdata_q <= a_wdata;
        owner   <= PORT_A;
      end else if (gnt_b) begin
        ADDR  <= b_addr;
        owner <= PORT_B;
      end
    end
  end

  // Completion: capture read data leaving RD2, pulse the owner's ack once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= ((state == RD2) && (owner == PORT_A)) || (state == WR3);
      b_ack <= (state == RD2) && (owner == PORT_B);
      if (state == RD2) begin
        if (owner == PORT_A) a_rdata <= DATA;
        else                 b_rdata <= DATA;
      end
    end
  end

  // Write data reaches the bus only in WR states, which never overlap the
  // read states where OEX is low.
  assign DATA = data_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase against a transaction-level
// memory model.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0;
  logic          a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata;
  logic          a_ack;
  logic          b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_rdata;
  logic          b_ack;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] DATA;
  logic          CSX;
  logic          OEX;
  logic          WEX;

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .a_ack   (a_ack),
    .b_req   (b_req),
    .b_addr  (b_addr),
    .b_rdata (b_rdata),
    .b_ack   (b_ack),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .CSX     (CSX),
    .OEX     (OEX),
    .WEX     (WEX)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM pin model (4K words, low address bits) ----------
  logic [DW-1:0] mem [0:4095];
  bit            mem_loaded = 1'b0;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h123) return 16'hBEEF;
    return 16'h5A00 ^ 16'(i);
  endfunction

  assign DATA = (!CSX && !OEX && WEX) ? mem[ADDR[11:0]] : 'z;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (rst_n && !CSX && !WEX) begin
      mem[ADDR[11:0]] <= DATA;
    end
  end

  // ---------------- Checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Bus safety on every cycle: while OEX is low only the SRAM may drive.
  always @(negedge clk) begin
    if (rst_n && !OEX) begin
      check("safe_wex_high", 32'(WEX), 32'd1);
      check("safe_bus_sram_only", 32'(DATA), 32'(mem[ADDR[11:0]]));
    end
  end

  // Reference memory: updated only at transaction level.
  logic [DW-1:0] ref_mem [0:4095];

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_cs;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run one isolated transfer and check its pin waveform and result.
  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0, low_cs = 0, low_oe = 0, low_we = 0, wrong_ack = 0;
    bit data_ok = 1'b1;
    logic [AW-1:0] addr_seen = '0;
    logic [DW-1:0] rd = '0;
    if (v.port_b) begin
      b_req = 1'b1; b_addr = v.addr;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) addr_seen = ADDR;
      if (!CSX) low_cs++;
      if (!OEX) low_oe++;
      if (!WEX) low_we++;
      if (!CSX && v.we && (DATA !== v.wdata)) data_ok = 1'b0;
      if (v.port_b ? a_ack : b_ack) wrong_ack++;
      if (v.port_b ? b_ack : a_ack) begin
        lat = cyc;
        rd  = v.port_b ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (v.we && lat != 0) ref_mem[v.addr[11:0]] = v.wdata;
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("vec%0d_addr", idx), 32'(addr_seen), 32'(v.addr));
    check($sformatf("vec%0d_csx_low_cycles", idx), 32'(low_cs), 32'(v.exp_cs));
    check($sformatf("vec%0d_oex_low_cycles", idx), 32'(low_oe), v.we ? 32'd0 : 32'd2);
    check($sformatf("vec%0d_wex_low_cycles", idx), 32'(low_we), v.we ? 32'd1 : 32'd0);
    check($sformatf("vec%0d_other_ack", idx), 32'(wrong_ack), 32'd0);
    if (v.we) check($sformatf("vec%0d_write_data_on_bus", idx), 32'(data_ok), 32'd1);
    else      check($sformatf("vec%0d_rdata", idx), 32'(rd), 32'(v.exp_rdata));
    @(negedge clk);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    vecs[0] = '{1'b0, 1'b0, 18'h00123, 16'h0000, 16'hBEEF, 3, 2};
    vecs[1] = '{1'b0, 1'b1, 18'h00010, 16'h1234, 16'h0000, 4, 3};
    vecs[2] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 16'h1234, 3, 2};
    vecs[3] = '{1'b1, 1'b0, 18'h00000, 16'h0000, 16'h5A00, 3, 2};
    vecs[4] = '{1'b1, 1'b0, 18'h00123, 16'h0000, 16'hBEEF, 3, 2};
    vecs[5] = '{1'b0, 1'b1, 18'h00FFF, 16'hA5A5, 16'h0000, 4, 3};
    vecs[6] = '{1'b1, 1'b0, 18'h00FFF, 16'h0000, 16'hA5A5, 3, 2};
    vecs[7] = '{1'b0, 1'b0, 18'h00002, 16'h0000, 16'h5A02, 3, 2};
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_csx", 32'(CSX), 32'd1);
    check("rst_oex", 32'(OEX), 32'd1);
    check("rst_wex", 32'(WEX), 32'd1);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Tie after reset: A, B, A, B.
    begin
      port_e order[$];
      do_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00001;
      b_req = 1'b1; b_addr = 18'h00002;
      for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
        @(negedge clk);
        if (a_ack && b_ack) check("tie_dual_ack", 32'd1, 32'(a_ack && b_ack && 1'b0));
        if (a_ack) begin
          order.push_back(PORT_A);
          check("tie_a_rdata", 32'(a_rdata), 32'(ref_mem[1]));
        end else if (b_ack) begin
          order.push_back(PORT_B);
          check("tie_b_rdata", 32'(b_rdata), 32'(ref_mem[2]));
        end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("tie_grant_count", 32'(order.size()), 32'd4);
      for (int k = 0; k < order.size(); k++)
        check($sformatf("tie_grant%0d_port", k), 32'(order[k]), (k % 2 == 0) ? 32'(PORT_A) : 32'(PORT_B));
      repeat (2) @(negedge clk);
    end

    // Back-to-back B reads: addresses 0,1,2, acks 3 cycles apart.
    begin
      int acks = 0, last_cyc = 0;
      b_req = 1'b1; b_addr = 18'h00000;
      for (int cyc = 1; cyc <= 20 && acks < 3; cyc++) begin
        @(negedge clk);
        check("b2b_no_a_ack", 32'(a_ack), 32'd0);
        if (b_ack) begin
          check($sformatf("b2b_rdata%0d", acks), 32'(b_rdata), 32'(ref_mem[acks]));
          if (acks > 0) check($sformatf("b2b_spacing%0d", acks), 32'(cyc - last_cyc), 32'd3);
          last_cyc = cyc;
          acks++;
          b_addr = 18'(acks);
          if (acks == 3) b_req = 1'b0;
        end
      end
      b_req = 1'b0;
      check("b2b_ack_count", 32'(acks), 32'd3);
      repeat (2) @(negedge clk);
    end

    // Reset asserted during WR2 aborts the write with no ack.
    begin
      int late_acks = 0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00020; a_wdata = 16'h1234;
      @(negedge clk);
      check("abort_wr1_csx", 32'(CSX), 32'd0);
      @(negedge clk);
      check("abort_wr2_wex", 32'(WEX), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_csx", 32'(CSX), 32'd1);
      check("abort_wex", 32'(WEX), 32'd1);
      check("abort_oex", 32'(OEX), 32'd1);
      check("abort_data_released", 32'(DATA !== 16'h1234), 32'd1);
      check("abort_addr", 32'(ADDR), 32'd0);
      a_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (a_ack || b_ack) late_acks++;
      end
      check("abort_no_ack_after_release", 32'(late_acks), 32'd0);
      run_vec('{1'b0, 1'b0, 18'h00020, 16'h0000, ref_mem['h20], 3, 2}, 8);
    end

    // Randomized traffic against the transaction-level model.
    begin
      bit            a_pend = 0, b_pend = 0;
      bit            a_we_q = 0;
      logic [11:0]   a_addr_q = '0, b_addr_q = '0;
      logic [DW-1:0] a_wdata_q = '0;
      logic [DW-1:0] exp_a_rd = '0, exp_b_rd = '0;
      int            a_wait = 0, b_wait = 0;
      int            last_port = 0;
      bit            other_pend = 0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
        @(negedge clk);
        if (a_pend) a_wait++;
        if (b_pend) b_wait++;
        if (a_ack) begin
          check("rnd_a_ack_expected", 32'(a_pend), 32'd1);
          check("rnd_a_wait_bound", 32'(a_wait <= 12), 32'd1);
          check("rnd_rr_a", 32'(!(last_port == 1 && other_pend)), 32'd1);
          if (a_we_q) ref_mem[a_addr_q] = a_wdata_q;
          else exp_a_rd = ref_mem[a_addr_q];
          a_pend = 0;
        end
        check("rnd_a_rdata", 32'(a_rdata), 32'(exp_a_rd));
        if (b_ack) begin
          check("rnd_b_ack_expected", 32'(b_pend), 32'd1);
          check("rnd_b_wait_bound", 32'(b_wait <= 12), 32'd1);
          check("rnd_rr_b", 32'(!(last_port == 2 && other_pend)), 32'd1);
          exp_b_rd = ref_mem[b_addr_q];
          b_pend = 0;
        end
        check("rnd_b_rdata", 32'(b_rdata), 32'(exp_b_rd));
        if (!a_pend) begin
          a_req = 1'b0;
          if (cyc < 780 && $urandom_range(0, 1) == 1) begin
            a_pend = 1; a_wait = 0;
            a_we_q = 1'($urandom_range(0, 1));
            a_addr_q = 12'($urandom_range(0, 4095));
            a_wdata_q = 16'($urandom);
            a_req = 1'b1; a_we = a_we_q; a_addr = 18'(a_addr_q); a_wdata = a_wdata_q;
          end
        end
        if (!b_pend) begin
          b_req = 1'b0;
          if (cyc < 780 && $urandom_range(0, 1) == 1) begin
            b_pend = 1; b_wait = 0;
            b_addr_q = 12'($urandom_range(0, 4095));
            b_req = 1'b1; b_addr = 18'(b_addr_q);
          end
        end
        if (a_ack) begin last_port = 1; other_pend = b_pend; end
        if (b_ack) begin last_port = 2; other_pend = a_pend; end
      end
      check("rnd_a_drained", 32'(a_pend), 32'd0);
      check("rnd_b_drained", 32'(b_pend), 32'd0);
    end

    a_req = 1'b0;
    b_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
